// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - Y86-64 five-stage hazard/stall/bubble control with sticky halt
// Define PIPE_CTRL_PERF_EN to add the saturating stall_cnt/bubble_cnt perf counters.
module pipe_ctrl #(
  parameter int STAT_W = 3,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        icode_d,
  input  logic [3:0]        srcA_d,
  input  logic [3:0]        srcB_d,
  input  logic [3:0]        icode_e,
  input  logic [3:0]        dstM_e,
  input  logic              e_cnd,
  input  logic [STAT_W-1:0] m_stat,
  input  logic [STAT_W-1:0] w_stat,
  output logic              f_stall,
  output logic              d_stall,
  output logic              d_bubble,
  output logic              e_bubble,
  output logic              m_bubble,
  output logic              w_stall,
  output logic              ret_busy,
  output logic              halted
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  localparam logic [STAT_W-1:0] S_HLT = STAT_W'(2);
  localparam logic [STAT_W-1:0] S_ADR = STAT_W'(3);
  localparam logic [STAT_W-1:0] S_INS = STAT_W'(4);

  typedef enum logic {RUN, HALTED} state_t;

  state_t     state, stateNext;
  logic [2:0] retSr, retSrNext;

  logic loadUse, misPred, retHz, mExc, wExc, retInD;

  always_comb begin
    retInD  = (icode_d == I_RET);
    loadUse = ((icode_e == I_MRMOVQ) || (icode_e == I_POPQ)) && (dstM_e != R_NONE) &&
              ((dstM_e == srcA_d) || (dstM_e == srcB_d));
    misPred = (icode_e == I_JXX) && !e_cnd;
    retHz   = retInD || retSr[0] || retSr[1];
    // Anything other than HLT/ADR/INS (including undefined codes) counts as AOK.
    mExc    = (m_stat == S_HLT) || (m_stat == S_ADR) || (m_stat == S_INS);
    wExc    = (w_stat == S_HLT) || (w_stat == S_ADR) || (w_stat == S_INS);
  end

  always_comb begin
    f_stall   = 1'b0;
    d_stall   = 1'b0;
    d_bubble  = 1'b0;
    e_bubble  = 1'b0;
    m_bubble  = 1'b0;
    w_stall   = 1'b0;
    stateNext = state;
    retSrNext = retSr;
    if (rst) begin
      d_bubble = 1'b1;
      e_bubble = 1'b1;
      m_bubble = 1'b1;
    end else if (state == HALTED) begin
      f_stall  = 1'b1;
      d_stall  = 1'b1;
      e_bubble = 1'b1;
      m_bubble = 1'b1;
      w_stall  = 1'b1;
    end else begin
      f_stall  = loadUse || retHz;
      d_stall  = loadUse;
      d_bubble = misPred || (retHz && !loadUse);
      e_bubble = misPred || loadUse;
      m_bubble = mExc || wExc;
      w_stall  = wExc;
      // A ret only advances into E when E is not being bubbled behind it.
      retSrNext = {retSr[1], retSr[0] && !m_bubble, retInD && !e_bubble};
      if (wExc) stateNext = HALTED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      retSr <= 3'b000;
    end else begin
      state <= stateNext;
      retSr <= retSrNext;
    end
  end

  assign ret_busy = retInD || (|retSr);
  assign halted   = (state == HALTED);

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (state == RUN) begin
      if (f_stall && !(&stall_cnt))   stall_cnt  <= stall_cnt + 1'b1;
      if (e_bubble && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - randomized and directed bench for pipe_ctrl against a stage-tracking model
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 32;
`endif
  localparam int STAT_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] icode_d, srcA_d, srcB_d, icode_e, dstM_e;
  logic e_cnd;
  logic [STAT_W-1:0] m_stat, w_stat;
  logic f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, ret_busy, halted;
`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt, bubble_cnt;
`endif

  pipe_ctrl #(.STAT_W(STAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .icode_d(icode_d), .srcA_d(srcA_d), .srcB_d(srcB_d),
    .icode_e(icode_e), .dstM_e(dstM_e), .e_cnd(e_cnd),
    .m_stat(m_stat), .w_stat(w_stat),
    .f_stall(f_stall), .d_stall(d_stall), .d_bubble(d_bubble), .e_bubble(e_bubble),
    .m_bubble(m_bubble), .w_stall(w_stall), .ret_busy(ret_busy), .halted(halted)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nErr = 0;

  // Model: each in-flight ret is tracked by the stage it occupies (0=E, 1=M, 2=W).
  bit     mHalt = 1'b0;
  int     retQ[$];
  longint mStall = 0, mBub = 0;
  longint cntMax = (64'd1 << CNT_W) - 1;

  function automatic bit isExc(logic [STAT_W-1:0] s);
    return (s == 2) || (s == 3) || (s == 4);
  endfunction

  // Vector order: f_stall d_stall d_bubble e_bubble m_bubble w_stall ret_busy halted
  function automatic logic [7:0] outs();
    return {f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, ret_busy, halted};
  endfunction

  function automatic logic [7:0] modelOut();
    bit lu, mp, rh, retE, retM, rb, me, we;
    logic [5:0] c;
    lu = (icode_e == 4'h5 || icode_e == 4'hB) && dstM_e != 4'hF &&
         (dstM_e == srcA_d || dstM_e == srcB_d);
    mp = (icode_e == 4'h7) && !e_cnd;
    retE = 0; retM = 0;
    foreach (retQ[i]) begin
      if (retQ[i] == 0) retE = 1;
      if (retQ[i] == 1) retM = 1;
    end
    rh = (icode_d == 4'h9) || retE || retM;
    rb = (icode_d == 4'h9) || (retQ.size() != 0);
    me = isExc(m_stat);
    we = isExc(w_stat);
    if (rst)        c = 6'b001110;
    else if (mHalt) c = 6'b110111;
    else            c = {lu | rh, lu, mp | (rh & !lu), mp | lu, me | we, we};
    return {c, rb, mHalt};
  endfunction

  task automatic setIn(input logic [3:0] id, sa, sb, ie, dm, input logic cnd,
                       input logic [STAT_W-1:0] ms, ws);
    icode_d = id; srcA_d = sa; srcB_d = sb; icode_e = ie; dstM_e = dm;
    e_cnd = cnd; m_stat = ms; w_stat = ws;
  endtask

  task automatic setNop();
    setIn(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 3'd1, 3'd1);
  endtask

  task automatic tick();
    logic [7:0] e;
    int nq[$];
    bit nHalt;
    longint nS, nB;
    e = modelOut();
    nHalt = mHalt; nS = mStall; nB = mBub;
    if (rst) begin
      nHalt = 0; nS = 0; nB = 0;
    end else if (!mHalt) begin
      foreach (retQ[i]) begin
        if (retQ[i] == 0 && !e[3]) nq.push_back(1);
        if (retQ[i] == 1) nq.push_back(2);
      end
      if (icode_d == 4'h9 && !e[4]) nq.push_back(0);
      if (e[7] && nS < cntMax) nS++;
      if (e[4] && nB < cntMax) nB++;
      if (isExc(w_stat)) nHalt = 1;
    end else begin
      nq = retQ;
    end
    @(posedge clk);
    retQ = nq; mHalt = nHalt; mStall = nS; mBub = nB;
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1; setNop(); tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    rst = 1'b1;
    setIn(4'h9, 4'h3, 4'h3, 4'h5, 4'h3, 1'b0, 3'd3, 3'd3);
    #1 got = outs(); nVec++;
    if (got[7:2] !== 6'b001110) begin nErr++; $display("FAIL reset_flush: got %b expected 001110", got[7:2]); end
    tick(); rst = 1'b0; setNop();
    #1 got = outs(); nVec++;
    if (got !== 8'b0000_0000) begin nErr++; $display("FAIL reset_state: got %b expected 00000000", got); end
`ifdef PIPE_CTRL_PERF_EN
    nVec++;
    if (stall_cnt !== '0 || bubble_cnt !== '0) begin
      nErr++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, bubble_cnt);
    end
`endif
  endtask

  task automatic test_loaduse();
    logic [7:0] got;
    doReset();
    setIn(4'h2, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 3'd1, 3'd1);
    #1 got = outs(); nVec++;
    if (got !== 8'b1101_0000 || got !== modelOut()) begin
      nErr++; $display("FAIL loaduse: got %b expected 11010000", got);
    end
    tick(); setNop();
    #1 got = outs(); nVec++;
    if (got !== 8'b0000_0000) begin nErr++; $display("FAIL loaduse_clear: got %b expected 00000000", got); end
    tick();
  endtask

  task automatic test_mispredict();
    logic [7:0] got;
    setIn(4'h2, 4'h1, 4'h2, 4'h7, 4'hF, 1'b0, 3'd1, 3'd1);
    #1 got = outs(); nVec++;
    if (got !== 8'b0011_0000) begin nErr++; $display("FAIL mispredict: got %b expected 00110000", got); end
    tick();
  endtask

  task automatic test_ret();
    logic [7:0] got;
    logic [7:0] exp[5] = '{8'b1010_0010, 8'b1010_0010, 8'b1010_0010, 8'b0000_0010, 8'b0000_0000};
    doReset();
    setNop(); icode_d = 4'h9;
    for (int i = 0; i < 5; i++) begin
      #1 got = outs(); nVec++;
      if (got !== exp[i]) begin nErr++; $display("FAIL ret_cycle%0d: got %b expected %b", i, got, exp[i]); end
      tick(); setNop();
    end
  endtask

  task automatic test_loaduse_ret();
    logic [7:0] got;
    logic [7:0] exp[6] = '{8'b1101_0010, 8'b1010_0010, 8'b1010_0010, 8'b1010_0010,
                          8'b0000_0010, 8'b0000_0000};
    doReset();
    setIn(4'h9, 4'hF, 4'h4, 4'hB, 4'h4, 1'b1, 3'd1, 3'd1);
    for (int i = 0; i < 6; i++) begin
      #1 got = outs(); nVec++;
      if (got !== exp[i]) begin nErr++; $display("FAIL loaduse_ret_cycle%0d: got %b expected %b", i, got, exp[i]); end
      tick(); setNop();
      if (i == 0) icode_d = 4'h9;
    end
  endtask

  task automatic test_exception();
    logic [7:0] got;
    doReset();
    setNop(); m_stat = 3'd3;
    #1 got = outs(); nVec++;
    if (got !== 8'b0000_1000) begin nErr++; $display("FAIL exc_mstat: got %b expected 00001000", got); end
    tick(); setNop(); w_stat = 3'd3;
    #1 got = outs(); nVec++;
    if (got !== 8'b0000_1100) begin nErr++; $display("FAIL exc_wstat: got %b expected 00001100", got); end
    tick(); setNop();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin icode_e = 4'h5; dstM_e = 4'h3; srcA_d = 4'h3; end
      #1 got = outs(); nVec++;
      if (got !== 8'b1101_1101) begin nErr++; $display("FAIL exc_halted%0d: got %b expected 11011101", i, got); end
      tick();
    end
    rst = 1'b1; setNop(); tick(); rst = 1'b0;
    #1 got = outs(); nVec++;
    if (got !== 8'b0000_0000) begin nErr++; $display("FAIL exc_cleared: got %b expected 00000000", got); end
    tick();
  endtask

  task automatic test_perf();
`ifdef PIPE_CTRL_PERF_EN
    doReset();
    for (int i = 0; i < 5; i++) begin
      setIn(4'h2, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 3'd1, 3'd1); tick();
    end
    setNop(); #1 nVec++;
    if (stall_cnt !== CNT_W'(5) || bubble_cnt !== CNT_W'(5)) begin
      nErr++; $display("FAIL perf_count: got %0d/%0d expected 5/5", stall_cnt, bubble_cnt);
    end
    for (int i = 0; i < 20; i++) begin
      setIn(4'h2, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 3'd1, 3'd1); tick();
    end
    setNop(); #1 nVec++;
    if (stall_cnt !== {CNT_W{1'b1}} || bubble_cnt !== {CNT_W{1'b1}}) begin
      nErr++; $display("FAIL perf_saturate: got %0d/%0d expected %0d", stall_cnt, bubble_cnt, cntMax);
    end
    tick();
`endif
  endtask

  task automatic test_random();
    logic [7:0] got, exp;
    logic [3:0] icodes[12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
    doReset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 39) == 0) || (mHalt && $urandom_range(0, 7) == 0);
      setIn(icodes[$urandom_range(0, 11)], 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            icodes[$urandom_range(0, 11)], 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd1,
            ($urandom_range(0, 39) == 0) ? 3'($urandom_range(0, 7)) : 3'd1);
      if ($urandom_range(0, 3) == 0) begin icode_e = 4'h5; srcB_d = dstM_e; end
      if ($urandom_range(0, 3) == 0) icode_d = 4'h9;
      #1 got = outs(); exp = modelOut(); nVec++;
      if (rst ? (got[7:2] !== exp[7:2]) : (got !== exp)) begin
        nErr++; $display("FAIL random%0d: got %b expected %b (rst=%0b)", i, got, exp, rst);
      end
`ifdef PIPE_CTRL_PERF_EN
      nVec++;
      if (stall_cnt !== CNT_W'(mStall) || bubble_cnt !== CNT_W'(mBub)) begin
        nErr++; $display("FAIL random_cnt%0d: got %0d/%0d expected %0d/%0d", i, stall_cnt, bubble_cnt, mStall, mBub);
      end
`endif
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    setNop();
    test_reset();
    test_loaduse();
    test_mispredict();
    test_ret();
    test_loaduse_ret();
    test_exception();
    test_perf();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
